// File: rtl/inv_share_arbiter.sv
// rtl/inv_share_arbiter.sv - round-robin sequencer sharing one fixed-latency inverter unit
//
// Purpose: accepts one request at a time from N_REQ requesters (rotating priority),
// drives the shared inverter unit for UNIT_LAT cycles, captures its result and returns
// it tagged with the requester index over a valid/ready response channel.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/req_data   per-requester request; requester i uses req_data[i*DATA_W +: DATA_W]
//   req_ready            one-hot accept strobe (IDLE only)
//   unit_a, unit_en      operand and enable to the shared inverter unit
//   unit_q               result from the shared inverter unit
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_data     served requester index and captured unit result
//   busy                 high whenever a transaction is in flight
module inv_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int UNIT_LAT = 1,
    parameter int ID_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       unit_a,
    output logic                    unit_en,
    input  logic [DATA_W-1:0]       unit_q,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy
);

    localparam int CNT_W = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     ptr;
    logic [CNT_W-1:0]    lat_cnt;
    logic [ID_W-1:0]     grant;
    logic                any_valid;
    logic                accept;
    logic [DATA_W-1:0]   grant_data;

    // Rotating-priority search starting at ptr. Walking the offsets from the far end
    // back toward ptr lets the nearest valid requester overwrite farther ones.
    always_comb begin
        grant     = ptr;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid[idx]) begin
                grant     = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept = (state == IDLE) && any_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state. req_ready is forced low while reset is asserted
    // so no requester sees a strobe that the datapath will not honour.
    always_comb begin
        req_ready = '0;
        if (!rst && accept) begin
            req_ready = N_REQ'(1) << grant;
        end
        unit_en = (state == BUSY);
        busy    = (state != IDLE);
    end

    // Datapath: pointer, operand, latency counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            unit_a    <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        unit_a  <= grant_data;
                        rsp_id  <= grant;
                        ptr     <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                        lat_cnt <= CNT_W'(UNIT_LAT - 1);
                    end
                end
                BUSY: begin
                    // Only the last BUSY edge samples unit_q; earlier values are junk.
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        rsp_data  <= unit_q;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_share_arbiter.sv
// tb/tb_inv_share_arbiter.sv - scoreboard bench for inv_share_arbiter
module tb_inv_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   unit_a;
    logic           unit_en;
    logic [W-1:0]   unit_q;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int en_cnt = 0;

    always #5 clk = ~clk;

    inv_share_arbiter #(
        .N_REQ   (N),
        .DATA_W  (W),
        .UNIT_LAT(LAT),
        .ID_W    (IDW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .unit_a   (unit_a),
        .unit_en  (unit_en),
        .unit_q   (unit_q),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Shared inverter unit: junk until the unit has been enabled for LAT cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) en_cnt <= 0;
        else     en_cnt <= unit_en ? en_cnt + 1 : 0;
    end
    assign unit_q = (unit_en && en_cnt == LAT - 1) ? ~unit_a : 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction occupies one idle-accept cycle, LAT busy
    // cycles, then a response phase until rsp_ready is seen.
    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
        bit           seen;
    } exp_t;

    exp_t         exp_q[$];
    int           m_ptr = 0;
    bit           pend  = 0;
    int           acc   = 0;
    logic [W-1:0] m_op  = '0;
    int           acc_cnt[N];
    int           drv_cnt[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0;
            drv_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend  = 0;
            m_ptr = 0;
            exp_q.delete();
        end else if (!pend) begin : idle_model
            int g;
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
            chk("req_ready_idle", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            chk("busy_idle", 32'(busy), 32'd0);
            chk("unit_en_idle", 32'(unit_en), 32'd0);
            if (g >= 0) begin
                pend  = 1;
                acc   = cyc + 1;
                m_op  = req_data[g*W +: W];
                m_ptr = (g + 1) % N;
                acc_cnt[g]++;
                exp_q.push_back('{id: g, data: ~m_op, due: acc + LAT, seen: 0});
            end
        end else if (cyc < acc + LAT) begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            chk("busy_busy", 32'(busy), 32'd1);
            chk("unit_en_busy", 32'(unit_en), 32'd1);
            chk("unit_a_busy", 32'(unit_a), 32'(m_op));
        end else begin
            chk("req_ready_resp", 32'(req_ready), 32'd0);
            chk("busy_resp", 32'(busy), 32'd1);
            chk("unit_en_resp", 32'(unit_en), 32'd0);
            chk("unit_a_resp", 32'(unit_a), 32'(m_op));
            if (rsp_ready) pend = 0;
        end
    end

    // Response monitor: compares whatever the DUT presents against the queue front.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!exp_q[0].seen) begin
                        chk("rsp_latency", 32'(cyc), 32'(exp_q[0].due));
                        exp_q[0].seen = 1;
                    end
                    chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                    chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0) begin
                if (exp_q[0].seen)
                    chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                else if (cyc == exp_q[0].due)
                    chk("rsp_valid_due", 32'(rsp_valid), 32'd1);
            end
        end
    end

    // One stimulus cycle: retire accepted requests, optionally raise new ones.
    task automatic step(input logic [N-1:0] allow, input int p_raise, input int p_rdy);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_cnt[i] != drv_cnt[i]) begin
                drv_cnt[i]   = acc_cnt[i];
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && allow[i] && $urandom_range(99) < p_raise) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = W'($urandom);
            end
        end
        rsp_ready = ($urandom_range(99) < p_rdy);
    endtask

    task automatic drain();
        req_valid = '0;
        for (int t = 0; t < 40 && (pend || exp_q.size() != 0); t++) step('0, 0, 100);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_unit_en"}, 32'(unit_en), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_unit_a"}, 32'(unit_a), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    endtask

    initial begin
        // Reset state, with requests pending to prove req_ready stays low.
        rst       = 1'b1;
        req_valid = 4'b0101;
        req_data  = 32'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        req_valid = '0;
        rst       = 1'b0;

        // Single request from requester 2.
        req_data[2*W +: W] = 8'h5A;
        req_valid          = 4'b0100;
        rsp_ready          = 1'b1;
        repeat (LAT + 4) step('0, 0, 100);

        // Fairness with every requester continuously requesting.
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        req_valid = 4'b1111;
        repeat (6 * (LAT + 2)) step(4'b1111, 100, 100);

        // Pointer skip: grant 3, then only 1 and 3 requesting.
        drain();
        req_data[3*W +: W] = W'($urandom);
        req_valid          = 4'b1000;
        repeat (LAT + 2) step('0, 0, 100);
        req_data[1*W +: W] = W'($urandom);
        req_data[3*W +: W] = W'($urandom);
        req_valid          = 4'b1010;
        repeat (2 * (LAT + 2) + 1) step('0, 0, 100);

        // Backpressure on a 0xF0 result with another requester waiting.
        drain();
        req_data[0*W +: W] = 8'h0F;
        req_valid          = 4'b0001;
        rsp_ready          = 1'b0;
        step('0, 0, 0);
        req_data[1*W +: W] = W'($urandom);
        req_valid[1]       = 1'b1;
        repeat (LAT + 5) step('0, 0, 0);
        repeat (2 * (LAT + 2)) step('0, 0, 100);

        // Reset during BUSY, then the lowest valid index must win.
        drain();
        req_data[2*W +: W] = W'($urandom);
        req_valid          = 4'b0100;
        step('0, 0, 100);
        req_data[1*W +: W] = W'($urandom);
        req_data[3*W +: W] = W'($urandom);
        req_valid          = 4'b1010;
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("midbusy_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant_after_reset", 32'(req_ready), 32'b0010);
        repeat (2 * (LAT + 2) + 2) step('0, 0, 100);

        // Randomized traffic with random backpressure.
        drain();
        repeat (400) step(4'b1111, 30, 60);

        drain();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(pend), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
